// File: rtl/line_burst_if.sv
// Cache-side line handshake and memory-side beat burst, seen from the adaptor
// (slave) or from whatever drives it (master).
//   cache side : line_i/line_o, address_i, read_i, write_i, resp_o
//   memory side: burst_i/burst_o, address_o, read_o, write_o, resp_i
interface line_burst_if #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [LINE_WIDTH-1:0] line_i;
    logic [LINE_WIDTH-1:0] line_o;
    logic [ADDR_WIDTH-1:0] address_i;
    logic                  read_i;
    logic                  write_i;
    logic                  resp_o;
    logic [BEAT_WIDTH-1:0] burst_i;
    logic [BEAT_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0] address_o;
    logic                  read_o;
    logic                  write_o;
    logic                  resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Turns one cacheline read/write into a 4-beat burst to memory and returns a
// single resp_o pulse per line transaction.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : line_burst_if.slave (cache handshake + memory burst signals)
// All outputs are decoded from registered state only; there is no
// combinational path from any input to any output.
module line_burst_adaptor #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    line_burst_if.slave  bus
);
    localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DONE  = 3'd2,
        WR_BURST = 3'd3,
        WR_DONE  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    line_t                 wbuf_q, wbuf_d;
    line_t                 rbuf_q, rbuf_d;

    logic                  resp_c;
    logic                  read_c;
    logic                  write_c;
    logic [ADDR_WIDTH-1:0] address_c;
    logic [BEAT_WIDTH-1:0] burst_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        rbuf_d    = rbuf_q;
        resp_c    = 1'b0;
        read_c    = 1'b0;
        write_c   = 1'b0;
        address_c = '0;
        burst_c   = '0;

        unique case (state_q)
            IDLE: begin
                // Read wins when both requests are up; resp_i is ignored here.
                if (bus.read_i) begin
                    addr_d  = bus.address_i & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end else if (bus.write_i) begin
                    addr_d  = bus.address_i & ALIGN_MASK;
                    wbuf_d  = bus.line_i;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end
            end
            RD_BURST: begin
                read_c    = 1'b1;
                address_c = addr_q;
                if (bus.resp_i) begin
                    rbuf_d[cnt_q] = bus.burst_i;
                    cnt_d         = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                resp_c  = 1'b1;
                state_d = IDLE;
            end
            WR_BURST: begin
                write_c   = 1'b1;
                address_c = addr_q;
                burst_c   = wbuf_q[cnt_q];
                if (bus.resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = WR_DONE;
                    end
                end
            end
            WR_DONE: begin
                resp_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.resp_o    = resp_c;
    assign bus.read_o    = read_c;
    assign bus.write_o   = write_c;
    assign bus.address_o = address_c;
    assign bus.burst_o   = burst_c;
    assign bus.line_o    = rbuf_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: a per-cycle vector table followed by
// hand-written back-to-back and asynchronous-reset sequences.
module tb_line_burst_adaptor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    line_burst_if bus ();

    line_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [63:0] Z64 = 64'h0;
    localparam logic [255:0] Z  = 256'h0;
    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] B5 = 64'h5555_0000_5555_0001;
    localparam logic [63:0] B6 = 64'h6666_0000_6666_0002;
    localparam logic [63:0] B7 = 64'h7777_0000_7777_0003;
    localparam logic [63:0] B8 = 64'h8888_0000_8888_0004;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] C0 = 64'h0C0C_0000_0000_0C00;
    localparam logic [63:0] C1 = 64'h0C1C_1111_0000_0C11;
    localparam logic [63:0] C2 = 64'h0C2C_2222_0000_0C22;
    localparam logic [63:0] C3 = 64'h0C3C_3333_0000_0C33;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [255:0] RL1 = {B4, B3, B2, B1};
    localparam logic [255:0] RL2 = {B8, B7, B6, B5};
    localparam logic [255:0] WL  = {WD, WC, WB, WA};
    localparam logic [255:0] L2  = {C3, C2, C1, C0};
    localparam logic [255:0] ONES = ~256'h0;

    typedef struct {
        logic          rd;
        logic          wr;
        logic          rsp;
        logic [31:0]   addr;
        logic [255:0]  line;
        logic [63:0]   burst;
        logic          e_resp;
        logic          e_rd;
        logic          e_wr;
        logic [31:0]   e_addr;
        logic [63:0]   e_burst;
        logic [255:0]  e_line;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic rsp,
                                input logic [31:0] addr, input logic [255:0] line,
                                input logic [63:0] burst, input logic e_resp,
                                input logic e_rd, input logic e_wr,
                                input logic [31:0] e_addr, input logic [63:0] e_burst,
                                input logic [255:0] e_line);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp; v.addr = addr; v.line = line; v.burst = burst;
        v.e_resp = e_resp; v.e_rd = e_rd; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_burst = e_burst; v.e_line = e_line;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic e_resp, input logic e_rd,
                             input logic e_wr, input logic [31:0] e_addr);
        check({tag, ".resp_o"},    256'(bus.resp_o),    256'(e_resp));
        check({tag, ".read_o"},    256'(bus.read_o),    256'(e_rd));
        check({tag, ".write_o"},   256'(bus.write_o),   256'(e_wr));
        check({tag, ".address_o"}, 256'(bus.address_o), 256'(e_addr));
    endtask

    task automatic drv(input logic rd, input logic wr, input logic rsp,
                       input logic [31:0] addr, input logic [63:0] burst);
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.resp_i    = rsp;
        bus.address_i = addr;
        bus.burst_i   = burst;
    endtask

    initial begin
        rst = 1'b0;
        bus.line_i = Z;
        drv(1'b0, 1'b0, 1'b0, 32'h0, Z64);

        // read, no stalls; line_o fills beat 0 first into bits 63:0
        vecs.push_back(mk(1, 0, 0, 32'h0000_1234, Z, Z64,   0, 0, 0, 32'h0, Z64, Z));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, B1,            0, 1, 0, 32'h0000_1220, Z64, Z));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, B2,            0, 1, 0, 32'h0000_1220, Z64, {192'h0, B1}));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, B3,            0, 1, 0, 32'h0000_1220, Z64, {128'h0, B2, B1}));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, B4,            0, 1, 0, 32'h0000_1220, Z64, {64'h0, B3, B2, B1}));
        vecs.push_back(mk(0, 0, 0, 32'h0, Z, Z64,           1, 0, 0, 32'h0, Z64, RL1));
        // write with stalls 1,0,1,0,1,1; line_i changes after acceptance
        vecs.push_back(mk(0, 1, 0, 32'h2000_0047, WL, Z64,  0, 0, 0, 32'h0, Z64, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WA, RL1));
        vecs.push_back(mk(0, 0, 0, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WB, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WB, RL1));
        vecs.push_back(mk(0, 0, 0, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WC, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WC, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, ONES, Z64,        0, 0, 1, 32'h2000_0040, WD, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, Z64,           1, 0, 0, 32'h0, Z64, RL1));
        // spurious resp_i in IDLE
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, JUNK,          0, 0, 0, 32'h0, Z64, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, JUNK,          0, 0, 0, 32'h0, Z64, RL1));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, JUNK,          0, 0, 0, 32'h0, Z64, RL1));
        // read and write together: read first, write after RD_DONE
        vecs.push_back(mk(1, 1, 0, 32'h0000_0100, WL, Z64,  0, 0, 0, 32'h0, Z64, RL1));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, WL, B5,   0, 1, 0, 32'h0000_0100, Z64, RL1));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, WL, B6,   0, 1, 0, 32'h0000_0100, Z64, {B4, B3, B2, B5}));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, WL, B7,   0, 1, 0, 32'h0000_0100, Z64, {B4, B3, B6, B5}));
        vecs.push_back(mk(0, 1, 1, 32'h0000_0100, WL, B8,   0, 1, 0, 32'h0000_0100, Z64, {B4, B7, B6, B5}));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0300, L2, Z64,  1, 0, 0, 32'h0, Z64, RL2));
        vecs.push_back(mk(0, 1, 0, 32'h0000_0300, L2, Z64,  0, 0, 0, 32'h0, Z64, RL2));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, Z64,           0, 0, 1, 32'h0000_0300, C0, RL2));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, Z64,           0, 0, 1, 32'h0000_0300, C1, RL2));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, Z64,           0, 0, 1, 32'h0000_0300, C2, RL2));
        vecs.push_back(mk(0, 0, 1, 32'h0, Z, Z64,           0, 0, 1, 32'h0000_0300, C3, RL2));
        vecs.push_back(mk(0, 0, 0, 32'h0, Z, Z64,           1, 0, 0, 32'h0, Z64, RL2));
        vecs.push_back(mk(0, 0, 0, 32'h0, Z, Z64,           0, 0, 0, 32'h0, Z64, RL2));

        repeat (2) @(negedge clk);
        check_ctl("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        check("reset.line_o", bus.line_o, Z);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_ctl($sformatf("vec%0d", i), vecs[i].e_resp, vecs[i].e_rd,
                      vecs[i].e_wr, vecs[i].e_addr);
            check($sformatf("vec%0d.burst_o", i), 256'(bus.burst_o), 256'(vecs[i].e_burst));
            check($sformatf("vec%0d.line_o", i), bus.line_o, vecs[i].e_line);
            drv(vecs[i].rd, vecs[i].wr, vecs[i].rsp, vecs[i].addr, vecs[i].burst);
            bus.line_i = vecs[i].line;
        end

        // back-to-back reads; address_i changes after acceptance
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b0, 32'h0000_0080, Z64);
        @(negedge clk);
        check_ctl("b2b.first", 1'b0, 1'b1, 1'b0, 32'h0000_0080);
        drv(1'b1, 1'b0, 1'b1, 32'h0000_0040, B1);
        @(negedge clk);
        check_ctl("b2b.beat1", 1'b0, 1'b1, 1'b0, 32'h0000_0080);
        drv(1'b1, 1'b0, 1'b1, 32'h0000_0040, B2);
        @(negedge clk);
        drv(1'b1, 1'b0, 1'b1, 32'h0000_0040, B3);
        @(negedge clk);
        check_ctl("b2b.beat3", 1'b0, 1'b1, 1'b0, 32'h0000_0080);
        drv(1'b1, 1'b0, 1'b1, 32'h0000_0040, B4);
        @(negedge clk);
        check_ctl("b2b.done1", 1'b1, 1'b0, 1'b0, 32'h0);
        check("b2b.line1", bus.line_o, RL1);
        drv(1'b1, 1'b0, 1'b0, 32'h0000_0040, Z64);
        @(negedge clk);
        check_ctl("b2b.idle", 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_ctl("b2b.second", 1'b0, 1'b1, 1'b0, 32'h0000_0040);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B5);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B6);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B7);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B8);
        @(negedge clk);
        check_ctl("b2b.done2", 1'b1, 1'b0, 1'b0, 32'h0);
        check("b2b.line2", bus.line_o, RL2);
        drv(1'b0, 1'b0, 1'b0, 32'h0, Z64);
        @(negedge clk);
        check_ctl("b2b.after", 1'b0, 1'b0, 1'b0, 32'h0);

        // asynchronous reset after two read beats
        drv(1'b1, 1'b0, 1'b0, 32'h0000_1000, Z64);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B1);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B2);
        @(negedge clk);
        check("rst.pre.line_o", bus.line_o, {B8, B7, B2, B1});
        drv(1'b0, 1'b0, 1'b0, 32'h0, Z64);
        #2 rst = 1'b0;
        #1;
        check_ctl("rst.async", 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst.async.line_o", bus.line_o, Z);
        @(negedge clk);
        rst = 1'b1;
        drv(1'b1, 1'b0, 1'b0, 32'h0000_1000, Z64);
        @(negedge clk);
        check_ctl("rst.reissue", 1'b0, 1'b1, 1'b0, 32'h0000_1000);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B4);
        @(negedge clk);
        check("rst.beat0", bus.line_o, {192'h0, B4});
        drv(1'b0, 1'b0, 1'b1, 32'h0, B3);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B2);
        @(negedge clk);
        drv(1'b0, 1'b0, 1'b1, 32'h0, B1);
        @(negedge clk);
        check_ctl("rst.done", 1'b1, 1'b0, 1'b0, 32'h0);
        check("rst.line", bus.line_o, {B1, B2, B3, B4});
        drv(1'b0, 1'b0, 1'b0, 32'h0, Z64);
        @(negedge clk);
        check_ctl("rst.idle", 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
